// File: rtl/ram_sdp_be_if.sv
// Bus bundle for the simple-dual-port byte-enable RAM: write port, read port
// and clear-engine control/status. Clock and reset stay outside the bundle.
interface ram_sdp_be_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16
);
   logic                    i_clr;
   logic                    o_busy;
   logic                    i_we;
   logic [DATA_WIDTH/8-1:0] i_be;
   logic [ADDR_WIDTH-1:0]   i_waddr;
   logic [DATA_WIDTH-1:0]   i_wdata;
   logic                    i_re;
   logic [ADDR_WIDTH-1:0]   i_raddr;
   logic [DATA_WIDTH-1:0]   o_rdata;
   logic                    o_rvalid;

   modport master (
      output i_clr, i_we, i_be, i_waddr, i_wdata, i_re, i_raddr,
      input  o_busy, o_rdata, o_rvalid
   );

   modport slave (
      input  i_clr, i_we, i_be, i_waddr, i_wdata, i_re, i_raddr,
      output o_busy, o_rdata, o_rvalid
   );
endinterface

// File: rtl/ram_sdp_be.sv
// Simple-dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and a clear engine
// that sweeps CLR_VALUE into every word after reset or on request.
module ram_sdp_be #(
   parameter int                    ADDR_WIDTH  = 4,
   parameter int                    DATA_WIDTH  = 16,
   parameter bit                    WRITE_FIRST = 1'b0,
   parameter bit                    OUT_REG     = 1'b0,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE   = '0
) (
   input logic         i_clk,
   input logic         i_rst_n,
   ram_sdp_be_if.slave bus
);
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH / 8;

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   old_word;
   logic [DATA_WIDTH-1:0]   merged;
   logic [DATA_WIDTH-1:0]   rd1_d;
   logic [DATA_WIDTH-1:0]   rd1_q;
   logic                    rv1_q;
   logic                    idle;

   assign idle       = (state_q == S_IDLE);
   assign bus.o_busy = (state_q == S_CLEAR);

   // Next first-stage read word; on a same-address collision the write-first
   // build forwards the byte-merged word instead of the array contents.
   always_comb begin
      old_word = mem_q[bus.i_raddr];
      merged   = old_word;
      for (int k = 0; k < NBYTES; k++) begin
         if (bus.i_be[k]) merged[8*k +: 8] = bus.i_wdata[8*k +: 8];
      end
      rd1_d = old_word;
      if (WRITE_FIRST && bus.i_we && (bus.i_waddr == bus.i_raddr)) rd1_d = merged;
   end

   // Clear/idle sequencer: the sweep always restarts at address 0.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               cnt_q <= cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == '1) state_q <= S_IDLE;
            end
            default: begin
               if (bus.i_clr) begin
                  state_q <= S_CLEAR;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   // Array write port: clear engine owns it in CLEAR, user byte writes in IDLE.
   // Reset never writes the array directly.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         if (!idle) begin
            mem_q[cnt_q] <= CLR_VALUE;
         end else if (bus.i_we) begin
            for (int k = 0; k < NBYTES; k++) begin
               if (bus.i_be[k]) mem_q[bus.i_waddr][8*k +: 8] <= bus.i_wdata[8*k +: 8];
            end
         end
      end
   end

   // First read stage: valid pulses per accepted read, data holds otherwise.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rv1_q <= 1'b0;
         rd1_q <= '0;
      end else if (idle && bus.i_re) begin
         rv1_q <= 1'b1;
         rd1_q <= rd1_d;
      end else begin
         rv1_q <= 1'b0;
      end
   end

   generate
      if (OUT_REG) begin : g_oreg
         logic                  rv2_q;
         logic [DATA_WIDTH-1:0] rd2_q;

         // Output stage is not flushed by CLEAR so a read in flight still lands.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               rv2_q <= 1'b0;
               rd2_q <= '0;
            end else begin
               rv2_q <= rv1_q;
               if (rv1_q) rd2_q <= rd1_q;
            end
         end

         assign bus.o_rvalid = rv2_q;
         assign bus.o_rdata  = rd2_q;
      end else begin : g_noreg
         assign bus.o_rvalid = rv1_q;
         assign bus.o_rdata  = rd1_q;
      end
   endgenerate
endmodule

// File: doc/ram_sdp_be.md
# ram_sdp_be

Parametrised simple-dual-port synchronous RAM with per-byte write enables, selectable read-during-write behaviour, an optional output register stage and a built-in clear engine. It succeeds the single-port synchronous RAM as the lab memory primitive: independent write and read ports, a read-valid strobe, and a guaranteed memory state after reset. It sits between datapath blocks (FIFOs, line buffers, register files) and the clock domain they share.

## Interface
- ADDR_WIDTH, 4: address bits; depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16: word width; must be a multiple of 8.
- WRITE_FIRST, 0: 0 returns old data on a same-address read/write collision; 1 returns the new, byte-merged word.
- OUT_REG, 0: 1 adds a pipeline register on read data and valid.
- CLR_VALUE, 0: word written to every location by the clear engine.
- i_clk, input, 1: single clock; all logic on the rising edge.
- i_rst_n, input, 1: reset, synchronous and active-low.
- i_clr, input, 1: request a full-memory clear; sampled only in IDLE.
- o_busy, output, 1: high while the clear engine owns the array.
- i_we, input, 1: write strobe.
- i_be, input, DATA_WIDTH/8: byte enables; bit k covers bits [8k+7:8k].
- i_waddr, input, ADDR_WIDTH: write address.
- i_wdata, input, DATA_WIDTH: write data.
- i_re, input, 1: read strobe.
- i_raddr, input, ADDR_WIDTH: read address.
- o_rdata, output, DATA_WIDTH: read data; holds its value between reads.
- o_rvalid, output, 1: o_rdata carries the result of a read issued L cycles earlier.

## Operation
- Two states, CLEAR and IDLE. While i_rst_n=0 at an edge: state goes to CLEAR, the clear counter to 0, o_busy to 1, o_rvalid (and its pipeline stage) to 0, and o_rdata (and its pipeline stage) to 0.
- CLEAR: each cycle writes CLR_VALUE to mem[cnt] and increments cnt. The cycle that writes DEPTH-1 moves to IDLE. The sweep takes exactly DEPTH cycles. i_we, i_re and i_clr are ignored. No write and no rvalid is generated.
- IDLE: i_clr=1 goes to CLEAR with cnt=0 on the next edge. A user write or read in that same cycle still executes.
- Write: i_we=1 updates only the bytes of mem[i_waddr] whose i_be bit is 1. i_we=1 with i_be=0 is a no-op.
- Read: i_re=1 captures mem[i_raddr] into the first read stage and sets valid.
  - i_re=0: valid clears and data holds.
- Collision (i_we and i_re both 1, i_waddr==i_raddr, IDLE):
  - WRITE_FIRST=0: read returns the pre-write word.
  - WRITE_FIRST=1: enabled bytes come from i_wdata, the other bytes from the pre-write word.
  - The memory itself is always updated.
- Different-address simultaneous write and read are fully independent.
- Reset asserted mid-clear restarts the sweep from address 0. Reset asserted with reads in flight drops their valids. Memory contents are not otherwise altered by reset, except through the subsequent clear.

## Timing
- Read latency L = 1 + OUT_REG cycles: i_re at edge n gives o_rvalid=1 and o_rdata valid after edge n+L.
- Back-to-back reads give back-to-back valids at full throughput, one per cycle.
- A write at edge n is visible to a read at edge n+1 regardless of WRITE_FIRST. At edge n itself, WRITE_FIRST governs.
- After release of i_rst_n, o_busy stays 1 for DEPTH cycles. The first accepted access is at edge DEPTH after release.
- i_clr accepted at edge n: o_busy=1 after edge n, and 0 after edge n+DEPTH.
- With OUT_REG=1, a read issued in the last IDLE cycle before a clear still returns valid L cycles later. The output stage is not flushed by entering CLEAR.

## Test plan
- Reset clear: defaults and CLR_VALUE=16'hA5A5, release reset → o_busy high for exactly 16 cycles; reads of addresses 0..15 then return 16'hA5A5 with o_rvalid one cycle after i_re.
- Byte enables: write 16'h1234 with i_be=2'b11 to addr 3, then 16'hABCD with i_be=2'b01 → read addr 3 returns 16'h12CD. A write with i_be=2'b00 leaves 16'h12CD.
- Collision: addr 5 holds 16'h0000; same-cycle write 16'hFFFF (i_be=2'b10) and read of addr 5:
  - WRITE_FIRST=0 returns 16'h0000.
  - WRITE_FIRST=1 returns 16'hFF00.
  - The next read returns 16'hFF00 in both builds.
- Latency/throughput: OUT_REG=1, 8 consecutive reads of addrs 0..7 holding value=addr → o_rvalid high for 8 consecutive cycles starting 2 cycles after the first i_re, with o_rdata 0..7 in order.
- Clear request: fill memory with 16'h5555, pulse i_clr in IDLE together with a write of 16'h7777 to addr 2.
  - o_busy is high for 16 cycles.
  - i_we/i_re issued during the clear produce no rvalid and no write.
  - Afterwards every address, including addr 2, reads CLR_VALUE.
- Reset mid-clear: assert i_rst_n=0 at clear cycle 7 for one cycle → o_busy stays 1 and the sweep restarts, finishing 16 cycles after release. A read issued just before the reset never raises o_rvalid.
